// File: rtl/dsu_pkg.sv
// Shared DSU definitions: fixed-point format, datapath widths, element layout
// helper and the rounding/ReLU/saturation step used by the output stages.
package dsu_pkg;

   localparam int DATA_WIDTH          = 16;
   localparam int CHANNEL_PARALLELISM = 4;
   localparam int FRAC_BITS           = 8;

   localparam int TAPS        = 9;
   localparam int PROD_WIDTH  = 2 * DATA_WIDTH;
   localparam int ROW_WIDTH   = 2 * DATA_WIDTH + 2;
   localparam int ACC_WIDTH   = 2 * DATA_WIDTH + 4;
   localparam int TAG_WIDTH   = 8;
   localparam int COUNT_WIDTH = 16;

   localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    = (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = -(ACC_WIDTH'(1) <<< (DATA_WIDTH - 1));

   // Sideband carried alongside each patch through the pipeline.
   typedef struct packed {
      logic [TAG_WIDTH-1:0] channel;
      logic                 last;
   } tag_t;

   // Flat element index of channel ch, kernel row, kernel col.
   function automatic int elem_idx(input int ch, input int row, input int col);
      return ch * TAPS + row * 3 + col;
   endfunction

   // Round half up, optional ReLU, then clamp into the DATA_WIDTH range.
   function automatic logic [DATA_WIDTH-1:0] sat_round(input logic signed [ACC_WIDTH-1:0] acc,
                                                       input logic relu);
      logic signed [ACC_WIDTH-1:0] rounded;
      logic [DATA_WIDTH-1:0]       result;
      rounded = (acc + ROUND_HALF) >>> FRAC_BITS;
      if (relu && rounded[ACC_WIDTH-1]) begin
         rounded = '0;
      end
      if (rounded > SAT_MAX) begin
         result = SAT_MAX[DATA_WIDTH-1:0];
      end else if (rounded < SAT_MIN) begin
         result = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         result = rounded[DATA_WIDTH-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/depthwise_mac_array_if.sv
// Patch-in / result-out stream bundle of the depthwise MAC array.
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// the producer keeps valid and payload stable until then, ready may depend
// combinationally on downstream ready but never on valid.
interface depthwise_mac_array_if;
   import dsu_pkg::*;

   logic [DATA_WIDTH*TAPS*CHANNEL_PARALLELISM-1:0] feature_in;
   logic [DATA_WIDTH*TAPS*CHANNEL_PARALLELISM-1:0] weight_in;
   logic [DATA_WIDTH*CHANNEL_PARALLELISM-1:0]      bias_in;
   logic                                           relu_en;
   logic [TAG_WIDTH-1:0]                           in_channel;
   logic                                           in_last;
   logic                                           in_valid;
   logic                                           in_ready;
   logic [DATA_WIDTH*CHANNEL_PARALLELISM-1:0]      out_data;
   logic [TAG_WIDTH-1:0]                           out_channel;
   logic                                           out_last;
   logic                                           out_valid;
   logic                                           out_ready;
   logic [COUNT_WIDTH-1:0]                         out_count;

   // MAC array side
   modport slave (
      input  feature_in, weight_in, bias_in, relu_en, in_channel, in_last, in_valid, out_ready,
      output in_ready, out_data, out_channel, out_last, out_valid, out_count
   );

   // Environment side: upstream producer plus downstream consumer
   modport master (
      output feature_in, weight_in, bias_in, relu_en, in_channel, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_channel, out_last, out_valid, out_count
   );

endinterface

// File: rtl/dw_lane.sv
// One channel of the depthwise datapath: 9 products, 3 row sums, total plus
// bias, then rounding/ReLU/saturation into the result register.
module dw_lane
   import dsu_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           adv,
   input  logic                           load_out,
   input  logic [TAPS*DATA_WIDTH-1:0]     feature,
   input  logic [TAPS*DATA_WIDTH-1:0]     weight,
   input  logic [DATA_WIDTH-1:0]          bias,
   input  logic                           relu,
   output logic [DATA_WIDTH-1:0]          result
);

   logic signed [PROD_WIDTH-1:0] prod_s1 [TAPS];
   logic signed [DATA_WIDTH-1:0] bias_s1;
   logic signed [DATA_WIDTH-1:0] bias_s2;
   logic                         relu_s1;
   logic                         relu_s2;
   logic                         relu_s3;
   logic signed [ROW_WIDTH-1:0]  row_s2 [3];
   logic signed [ACC_WIDTH-1:0]  acc_s3;
   logic signed [ACC_WIDTH-1:0]  bias_scaled;

   // Bias is in the feature format; align it with the product fraction.
   assign bias_scaled = ACC_WIDTH'(bias_s2) <<< FRAC_BITS;

   // S1: per-tap signed products, bias and ReLU select latched with them.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               prod_s1[elem_idx(0, r, c)] <=
                  PROD_WIDTH'($signed(feature[elem_idx(0, r, c)*DATA_WIDTH +: DATA_WIDTH])) *
                  PROD_WIDTH'($signed(weight[elem_idx(0, r, c)*DATA_WIDTH +: DATA_WIDTH]));
            end
         end
         bias_s1 <= $signed(bias);
         relu_s1 <= relu;
      end
   end

   // S2: one three-input sum per kernel row.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int r = 0; r < 3; r++) begin
            row_s2[r] <= ROW_WIDTH'(prod_s1[elem_idx(0, r, 0)]) +
                         ROW_WIDTH'(prod_s1[elem_idx(0, r, 1)]) +
                         ROW_WIDTH'(prod_s1[elem_idx(0, r, 2)]);
         end
         bias_s2 <= bias_s1;
         relu_s2 <= relu_s1;
      end
   end

   // S3: full accumulation; ACC_WIDTH leaves headroom for 9 worst-case products plus bias.
   always_ff @(posedge clk) begin
      if (adv) begin
         acc_s3  <= ACC_WIDTH'(row_s2[0]) + ACC_WIDTH'(row_s2[1]) + ACC_WIDTH'(row_s2[2]) + bias_scaled;
         relu_s3 <= relu_s2;
      end
   end

   // S4: result register, only reloaded when a valid patch leaves S3.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
      end else if (load_out) begin
         result <= sat_round(acc_s3, relu_s3);
      end
   end

endmodule

// File: rtl/depthwise_mac_array.sv
// Depthwise 3x3 MAC array: CHANNEL_PARALLELISM lanes behind a 4-stage
// pipeline that advances as a whole whenever the output slot can move.
module depthwise_mac_array
   import dsu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   depthwise_mac_array_if.slave  bus
);

   logic                                      adv;
   logic                                      valid_s1;
   logic                                      valid_s2;
   logic                                      valid_s3;
   logic                                      out_valid_q;
   tag_t                                      tag_s1;
   tag_t                                      tag_s2;
   tag_t                                      tag_s3;
   tag_t                                      out_tag_q;
   logic [COUNT_WIDTH-1:0]                    count_q;
   logic [DATA_WIDTH*CHANNEL_PARALLELISM-1:0] lane_result;

   // Global stall: everything moves unless a result sits unaccepted at the output.
   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;

   assign bus.out_valid   = out_valid_q;
   assign bus.out_channel = out_tag_q.channel;
   assign bus.out_last    = out_tag_q.last;
   assign bus.out_count   = count_q;
   assign bus.out_data    = lane_result;

   // Valid bits; a reset drops whatever is in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_s1    <= 1'b0;
         valid_s2    <= 1'b0;
         valid_s3    <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         valid_s1    <= bus.in_valid;
         valid_s2    <= valid_s1;
         valid_s3    <= valid_s2;
         out_valid_q <= valid_s3;
      end
   end

   // Channel tag and last flag travel in step with the data.
   always_ff @(posedge clk) begin
      if (adv) begin
         tag_s1 <= '{channel: bus.in_channel, last: bus.in_last};
         tag_s2 <= tag_s1;
         tag_s3 <= tag_s2;
      end
   end

   // Output tag register, updated together with the lane result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_tag_q <= '0;
      end else if (adv && valid_s3) begin
         out_tag_q <= tag_s3;
      end
   end

   // Delivered-result counter; a delivered last result restarts it at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (out_valid_q && bus.out_ready) begin
         count_q <= out_tag_q.last ? '0 : count_q + COUNT_WIDTH'(1);
      end
   end

   for (genvar g = 0; g < CHANNEL_PARALLELISM; g++) begin : g_lane
      dw_lane u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .adv      (adv),
         .load_out (adv && valid_s3),
         .feature  (bus.feature_in[g*TAPS*DATA_WIDTH +: TAPS*DATA_WIDTH]),
         .weight   (bus.weight_in[g*TAPS*DATA_WIDTH +: TAPS*DATA_WIDTH]),
         .bias     (bus.bias_in[g*DATA_WIDTH +: DATA_WIDTH]),
         .relu     (bus.relu_en),
         .result   (lane_result[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_depthwise_mac_array.sv
// Self-checking bench for depthwise_mac_array: directed vector table,
// randomized traffic against an arithmetic reference, stall/reset sequences.
module tb_depthwise_mac_array;
   import dsu_pkg::*;

   localparam int DW   = DATA_WIDTH;
   localparam int CP   = CHANNEL_PARALLELISM;
   localparam int FW   = DW * TAPS * CP;
   localparam int BW   = DW * CP;
   localparam int SB_W = 8 + 1 + BW;

   typedef struct {
      string       name;
      logic [15:0] f_fill;
      logic [15:0] w_fill;
      logic [15:0] f_tap;
      logic [15:0] w_tap;
      logic [15:0] bias;
      logic        relu;
      logic [15:0] exp_lane;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   depthwise_mac_array_if bus();

   depthwise_mac_array dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_pass = 0;
   int n_total = 0;
   int n_delivered = 0;
   logic [15:0] exp_cnt = '0;
   logic [SB_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: exact integer sum, floor((sum + half) / 2^F), ReLU, clamp.
   function automatic logic [BW-1:0] ref_result(input logic [FW-1:0] f, input logic [FW-1:0] w,
                                                input logic [BW-1:0] b, input logic relu);
      logic [BW-1:0] r;
      longint acc;
      longint q;
      longint hi;
      longint lo;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -(longint'(1) << (DW - 1));
      r = '0;
      for (int i = 0; i < CP; i++) begin
         acc = longint'($signed(b[i*DW +: DW])) * (longint'(1) << FRAC_BITS);
         for (int k = 0; k < TAPS; k++) begin
            acc += longint'($signed(f[(i*TAPS+k)*DW +: DW])) * longint'($signed(w[(i*TAPS+k)*DW +: DW]));
         end
         q = (acc + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
         if (relu && q < 0) q = 0;
         if (q > hi) q = hi;
         if (q < lo) q = lo;
         r[i*DW +: DW] = q[DW-1:0];
      end
      return r;
   endfunction

   function automatic logic [15:0] rand_elem();
      logic [15:0] e;
      if ($urandom_range(0, 1) == 1) e = 16'($urandom);
      else e = 16'($urandom_range(0, 1023)) - 16'd512;
      return e;
   endfunction

   task automatic drive(input logic [FW-1:0] f, input logic [FW-1:0] w, input logic [BW-1:0] b,
                        input logic relu, input logic [7:0] ch, input logic last);
      bus.feature_in = f;
      bus.weight_in  = w;
      bus.bias_in    = b;
      bus.relu_en    = relu;
      bus.in_channel = ch;
      bus.in_last    = last;
      bus.in_valid   = 1'b1;
   endtask

   task automatic drive_random(input logic [7:0] ch, input logic last);
      logic [FW-1:0] f;
      logic [FW-1:0] w;
      logic [BW-1:0] b;
      for (int k = 0; k < TAPS * CP; k++) begin
         f[k*DW +: DW] = rand_elem();
         w[k*DW +: DW] = rand_elem();
      end
      for (int i = 0; i < CP; i++) b[i*DW +: DW] = rand_elem();
      drive(f, w, b, 1'($urandom_range(0, 1)), ch, last);
   endtask

   // Called just after a posedge with a transfer driven: the first edge
   // accepts it, then counts edges until out_valid shows.
   task automatic wait_out(output int cycles, output bit found);
      found = 1'b0;
      cycles = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (c == 0) bus.in_valid = 1'b0;
         if (bus.out_valid) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         @(posedge clk);
         #1;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard input side: record the expected result of each accepted patch.
   always @(negedge clk) begin
      if (rst_n && bus.in_valid && bus.in_ready) begin
         exp_q.push_back({bus.in_channel, bus.in_last,
                          ref_result(bus.feature_in, bus.weight_in, bus.bias_in, bus.relu_en)});
      end
   end

   // Scoreboard output side: compare deliveries in order and track out_count.
   always @(negedge clk) begin
      logic [SB_W-1:0] e;
      if (!rst_n) begin
         exp_cnt = '0;
      end else begin
         check("out_count", 64'(bus.out_count), 64'(exp_cnt));
         if (bus.out_valid && bus.out_ready) begin
            n_delivered++;
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_output: got channel %0d data %h expected no result",
                        bus.out_channel, bus.out_data);
               exp_cnt = exp_cnt + 16'd1;
            end else begin
               e = exp_q.pop_front();
               check("sb_data", 64'(bus.out_data), 64'(e[BW-1:0]));
               check("sb_channel", 64'(bus.out_channel), 64'(e[SB_W-1 -: 8]));
               check("sb_last", 64'(bus.out_last), 64'(e[BW]));
               exp_cnt = e[BW] ? 16'd0 : exp_cnt + 16'd1;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      logic [FW-1:0] f;
      logic [FW-1:0] w;
      logic [BW-1:0] b;
      int cycles;
      bit found;
      int sent;
      int deliv0;

      vecs[0] = '{"unity",       16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0900};
      vecs[1] = '{"neg_weight",  16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0080, 1'b0, 16'hF780};
      vecs[2] = '{"neg_relu",    16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0080, 1'b1, 16'h0000};
      vecs[3] = '{"sat_pos",     16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF};
      vecs[4] = '{"sat_neg",     16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 16'h8000};
      vecs[5] = '{"round_up",    16'h0000, 16'h0000, 16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0001};
      vecs[6] = '{"round_half",  16'h0000, 16'h0000, 16'h0001, 16'hFF80, 16'h0000, 1'b0, 16'h0000};
      vecs[7] = '{"round_below", 16'h0000, 16'h0000, 16'h0001, 16'hFF7F, 16'h0000, 1'b0, 16'hFFFF};

      bus.feature_in = '0;
      bus.weight_in  = '0;
      bus.bias_in    = '0;
      bus.relu_en    = 1'b0;
      bus.in_channel = '0;
      bus.in_last    = 1'b0;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_channel", 64'(bus.out_channel), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
      check("rst_out_count", 64'(bus.out_count), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed vector table
      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < TAPS * CP; k++) begin
            f[k*DW +: DW] = (k % TAPS == 0) ? vecs[v].f_tap : vecs[v].f_fill;
            w[k*DW +: DW] = (k % TAPS == 0) ? vecs[v].w_tap : vecs[v].w_fill;
         end
         for (int i = 0; i < CP; i++) b[i*DW +: DW] = vecs[v].bias;
         drive(f, w, b, vecs[v].relu, 8'(v * 4), 1'b0);
         wait_out(cycles, found);
         check({vecs[v].name, "_found"}, 64'(found), 64'd1);
         if (v == 0) check("latency", 64'(cycles), 64'd4);
         for (int i = 0; i < CP; i++) begin
            check({vecs[v].name, "_lane"}, 64'(bus.out_data[i*DW +: DW]), 64'(vecs[v].exp_lane));
         end
         @(posedge clk);
         #1;
         if (v == 0) check("count_after_first", 64'(bus.out_count), 64'd1);
      end

      // Randomized traffic with random bubbles and backpressure
      for (int c = 0; c < 300; c++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0) drive_random(8'($urandom), ($urandom_range(0, 9) == 0));
         else bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain("random_drain");

      // Six back-to-back transfers, downstream stalled in cycles 5-7
      sent = 0;
      deliv0 = n_delivered;
      for (int cyc = 0; cyc < 30; cyc++) begin
         bus.out_ready = !(cyc >= 5 && cyc <= 7);
         if (sent < 6) drive_random(8'(sent * 4), 1'b0);
         else bus.in_valid = 1'b0;
         @(negedge clk);
         if (cyc >= 5 && cyc <= 7) check("in_ready_stalled", 64'(bus.in_ready), 64'd0);
         if (cyc == 4 || cyc == 8) check("in_ready_open", 64'(bus.in_ready), 64'd1);
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk);
         #1;
      end
      check("bp_accepted", 64'(sent), 64'd6);
      check("bp_delivered", 64'(n_delivered - deliv0), 64'd6);
      check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // Last-of-layer transfer clears the counter after delivery
      drive_random(8'h55, 1'b1);
      wait_out(cycles, found);
      check("last_found", 64'(found), 64'd1);
      check("last_flag", 64'(bus.out_last), 64'd1);
      check("last_channel", 64'(bus.out_channel), 64'h55);
      @(posedge clk);
      #1;
      check("count_cleared", 64'(bus.out_count), 64'd0);

      // Reset with two patches in flight: nothing may come out afterwards
      drive_random(8'd1, 1'b0);
      @(posedge clk);
      #1;
      drive_random(8'd2, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("post_reset_quiet", 64'(bus.out_valid), 64'd0);
      end
      check("post_reset_count", 64'(bus.out_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/depthwise_mac_array.md
Name: depthwise_mac_array

Overview:
Downstream consumer of the pixel-window stage. It takes one 3x3 patch for CHANNEL_PARALLELISM channels per transfer, together with the matching per-channel 3x3 weights and bias. It produces one fixed-point depthwise result per channel through a 4-stage pipeline with valid/ready backpressure. Results feed the pointwise stage of the DSU.

Parameters:
DATA_WIDTH, 16, signed element width (feature, weight, bias, result)
CHANNEL_PARALLELISM, 4, channels processed per transfer
FRAC_BITS, 8, fractional bits of the Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS format; must be >=1

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  synchronous active-low reset
feature_in  in  DATA_WIDTH*9*CHANNEL_PARALLELISM  patch; element (i*9+j*3+k) = channel i, row j, col k
weight_in  in  DATA_WIDTH*9*CHANNEL_PARALLELISM  kernels, same element order as feature_in
bias_in  in  DATA_WIDTH*CHANNEL_PARALLELISM  per-channel bias, same Q format
relu_en  in  1  apply ReLU to this transfer
in_channel  in  8  channel group tag (base channel index)
in_last  in  1  marks last patch of the layer
in_valid  in  1  input transfer request
in_ready  out  1  input accepted when in_valid&&in_ready
out_data  out  DATA_WIDTH*CHANNEL_PARALLELISM  results; lane i = channel in_channel+i
out_channel  out  8  tag carried with the result
out_last  out  1  carried in_last
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid&&out_ready
out_count  out  16  results delivered since reset or since the last in_last delivery

Behaviour:
- Reset (rst_n=0 at a clock edge): all stage valid bits=0; out_valid=0, out_data=0, out_channel=0, out_last=0, out_count=0. Reset takes effect mid-stream too; in-flight patches are discarded and nothing is emitted for them.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv=0, all stages hold their data and valid bits.
- S1 (multiply): 9*CP signed products, each 2*DATA_WIDTH bits. Latches relu_en, in_channel, in_last and bias.
- S2 (row sums): three 3-input sums per channel, width 2*DW+2.
- S3 (total): sum of the rows plus (bias sign-extended and shifted left by FRAC_BITS), width 2*DW+4. No overflow is possible at this width.
- S4 (output):
  - Add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up toward +inf).
  - If relu_en and the result is negative, the result is 0.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - Register into out_data.
- Latency: 4 clocks from an accepted input to out_valid, with no stalls. Throughput is 1 per clock while out_ready=1.
- The stall bubble is not squeezed. A simple global enable is sufficient, and in_ready deasserts the same cycle out_valid&&!out_ready.
- in_valid=0 inserts a bubble; the valid bit propagates as 0.
- out_count:
  - Increments by 1 on each out_valid&&out_ready.
  - On a handshake with out_last=1, it clears to 0 on the next clock; the increment is not applied.
  - Wraps at 16 bits.
- Simultaneous input accept and output stall is impossible by construction (in_ready=0).
- Data is unchanged while out_valid&&!out_ready.

Decomposition:
- Shared package (dsu_pkg):
  - constants DATA_WIDTH, FRAC_BITS, CHANNEL_PARALLELISM
  - function sat_round(acc, relu) for rounding, ReLU and saturation, reused by the pointwise stage
  - element-index helper for the (i*9+j*3+k) layout
- One sub-module: dw_lane. One channel's S1–S4 datapath, instantiated CHANNEL_PARALLELISM times. The top holds the valid/tag pipeline, the handshake and out_count.

Test Plan:
- All features 0x0100, weights 0x0100, bias 0, relu_en=0, one transfer -> out_valid exactly 4 clocks later; every lane 0x0900; out_count 1.
- Weights 0xFF00 (-1.0), features 0x0100, bias 0x0080 -> lanes 0xF780 with relu_en=0; lanes 0x0000 with relu_en=1.
- Features 0x7FFF, weights 0x7FFF, bias 0x7FFF -> lanes 0x7FFF. Weights 0x8000 -> lanes 0x8000 (relu_en=0).
- Rounding: a single tap with feature 0x0001 and weight 0x0080, all else 0 -> lane 0x0001. Weight 0xFF80 -> 0x0000. Weight 0xFF7F -> 0xFFFF.
- Six back-to-back transfers with distinct in_channel 0,4,…,20 and out_ready low for cycles 5–7 -> in_ready low in those cycles. All six results arrive in order with correct tags, none lost or duplicated.
- Transfer with in_last=1 delivered -> out_last=1, out_count returns to 0 next clock. Then rst_n=0 for one clock with 2 patches in flight -> out_valid stays 0 and no stale results appear afterwards.
